// File: rtl/spi_master_if.sv
// Host-side and SPI-side signals of the byte-wide SPI master.
// The master modport is the view seen by spi_master itself; the slave modport is
// the view of whatever drives it (host logic plus the SPI partner).
interface spi_master_if;
    logic       i_start;
    logic [7:0] i_tx_data;
    logic       i_hold;
    logic       i_miso;
    logic [7:0] o_rx_data;
    logic       o_busy;
    logic       o_done;
    logic       o_sck;
    logic       o_ss;
    logic       o_mosi;

    modport master (
        input  i_start, i_tx_data, i_hold, i_miso,
        output o_rx_data, o_busy, o_done, o_sck, o_ss, o_mosi
    );

    modport slave (
        output i_start, i_tx_data, i_hold, i_miso,
        input  o_rx_data, o_busy, o_done, o_sck, o_ss, o_mosi
    );
endinterface

// File: rtl/spi_master.sv
// Byte-wide SPI mode-0 master: MSB first, mosi launched while sck is low,
// miso sampled at the end of each sck-high phase. One down-counter times every
// phase; a 3-bit index tracks the bit. All SPI outputs come straight from flops.
module spi_master #(
    parameter int CLK_DIV = 25,
    parameter int GUARD   = 25
) (
    input logic          clk,
    input logic          rst,
    spi_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, TAIL} state_t;

    localparam int MAXV = (CLK_DIV > GUARD) ? CLK_DIV : GUARD;
    localparam int CW   = $clog2(MAXV + 1);
    // SETUP is loaded with GUARD (not GUARD-1): the accept cycle plus GUARD
    // counted cycles give the 1 + 2*GUARD + 16*CLK_DIV start-to-done latency.
    localparam logic [CW-1:0] SETUP_LOAD = CW'(GUARD);
    localparam logic [CW-1:0] TAIL_LOAD  = CW'(GUARD - 1);
    localparam logic [CW-1:0] DIV_LOAD   = CW'(CLK_DIV - 1);

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [2:0]    r_bit, w_bit_next;
    logic [7:0]    r_tx_shift, w_tx_shift_next;
    logic [7:0]    r_rx_shift, w_rx_shift_next;
    logic [7:0]    r_rx_data, w_rx_data_next;
    logic          r_busy, w_busy_next;
    logic          r_done, w_done_next;
    logic          r_sck, w_sck_next;
    logic          r_ss, w_ss_next;
    logic          r_mosi, w_mosi_next;
    logic          w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    // State and datapath registers; reset aborts any transfer in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sck      <= 1'b0;
            r_ss       <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit      <= w_bit_next;
            r_tx_shift <= w_tx_shift_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_data  <= w_rx_data_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_sck      <= w_sck_next;
            r_ss       <= w_ss_next;
            r_mosi     <= w_mosi_next;
        end
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_bit_next      = r_bit;
        w_tx_shift_next = r_tx_shift;
        w_rx_shift_next = r_rx_shift;
        w_rx_data_next  = r_rx_data;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_sck_next      = r_sck;
        w_ss_next       = r_ss;
        w_mosi_next     = r_mosi;

        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_state_next    = SETUP;
                    w_cnt_next      = SETUP_LOAD;
                    w_bit_next      = 3'd7;
                    w_tx_shift_next = bus.i_tx_data;
                    w_busy_next     = 1'b1;
                    w_ss_next       = 1'b0;
                    w_sck_next      = 1'b0;
                    w_mosi_next     = bus.i_tx_data[7];
                end else if (!r_ss && !bus.i_hold) begin
                    // a held frame is being closed by the host
                    w_ss_next = 1'b1;
                end
            end
            SETUP: begin
                if (w_cnt_zero) begin
                    w_state_next = LOW;
                    w_cnt_next   = DIV_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            LOW: begin
                if (w_cnt_zero) begin
                    w_state_next = HIGH;
                    w_cnt_next   = DIV_LOAD;
                    w_sck_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            HIGH: begin
                if (w_cnt_zero) begin
                    w_rx_shift_next = {r_rx_shift[6:0], bus.i_miso};
                    w_sck_next      = 1'b0;
                    if (r_bit != 3'd0) begin
                        w_state_next    = LOW;
                        w_cnt_next      = DIV_LOAD;
                        w_bit_next      = r_bit - 1'b1;
                        w_tx_shift_next = {r_tx_shift[6:0], 1'b0};
                        w_mosi_next     = r_tx_shift[6];
                    end else begin
                        w_state_next = TAIL;
                        w_cnt_next   = TAIL_LOAD;
                        w_mosi_next  = 1'b0;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            TAIL: begin
                if (w_cnt_zero) begin
                    w_state_next   = IDLE;
                    w_rx_data_next = r_rx_shift;
                    w_done_next    = 1'b1;
                    w_busy_next    = 1'b0;
                    w_ss_next      = !bus.i_hold;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.o_rx_data = r_rx_data;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_sck     = r_sck;
    assign bus.o_ss      = r_ss;
    assign bus.o_mosi    = r_mosi;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a main instance (CLK_DIV=4, GUARD=2) with a
// behavioural mode-0 slave, and a boundary instance (CLK_DIV=1, GUARD=1).
module tb_spi_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spi_master_if m_if ();
    spi_master_if b_if ();

    spi_master #(.CLK_DIV(4), .GUARD(2)) u_main (.clk(clk), .rst(rst), .bus(m_if));
    spi_master #(.CLK_DIV(1), .GUARD(1)) u_bnd  (.clk(clk), .rst(rst), .bus(b_if));

    // ---------------- main-instance slave model and monitor ----------------
    logic [7:0] s_arr [8];
    logic [2:0] s_idx = '0;
    logic [7:0] s_shift = '0;
    logic [7:0] s_din = '0;
    int         s_cnt = 0;
    logic [7:0] din_q [$];
    int         hi_q [$];
    int         lo_q [$];
    int         hi_cnt = 0, lo_cnt = 0;
    bit         lo_valid = 0;
    int         rise_cnt = 0, done_cnt = 0, ss_rise_cnt = 0;
    logic [7:0] mosi_byte = '0;
    logic       p_sck = 1'b0, p_ss = 1'b1;

    assign m_if.i_miso = s_shift[7];

    // Slave: load on ss fall, capture mosi on sck rise, launch next bit on sck fall.
    always @(negedge clk) begin
        if (m_if.o_done) begin
            done_cnt++;
            lo_valid = 0;
        end
        if (m_if.o_ss && !p_ss) begin
            ss_rise_cnt++;
            s_cnt = 0;
            lo_valid = 0;
        end
        if (!m_if.o_ss && p_ss) begin
            s_shift = s_arr[0];
            s_idx = 3'd1;
            s_cnt = 0;
        end
        if (m_if.o_sck && !p_sck) begin
            rise_cnt++;
            mosi_byte = {mosi_byte[6:0], m_if.o_mosi};
            s_din = {s_din[6:0], m_if.o_mosi};
            s_cnt++;
            if (s_cnt == 8) din_q.push_back(s_din);
            if (lo_valid) lo_q.push_back(lo_cnt);
            hi_cnt = 0;
        end
        if (!m_if.o_sck && p_sck) begin
            hi_q.push_back(hi_cnt);
            lo_cnt = 0;
            lo_valid = 1;
            if (s_cnt == 8) begin
                s_shift = s_arr[s_idx];
                s_idx = s_idx + 3'd1;
                s_cnt = 0;
            end else begin
                s_shift = {s_shift[6:0], 1'b0};
            end
        end
        if (m_if.o_sck) hi_cnt++;
        else lo_cnt++;
        p_sck = m_if.o_sck;
        p_ss  = m_if.o_ss;
    end

    // ---------------- boundary-instance monitor (returns 0x01) ----------------
    int         b_falls = 0, b_rises = 0, b_cyc = 0, b_first_rise = 0, b_last_fall = 0;
    logic [7:0] b_mosi = '0;
    logic       b_p_sck = 1'b0, b_p_ss = 1'b1;

    assign b_if.i_miso = (b_falls == 7);

    // Tracks boundary sck edges; miso goes high only for the last bit.
    always @(negedge clk) begin
        b_cyc++;
        if (!b_if.o_ss && b_p_ss) begin
            b_falls = 0;
            b_rises = 0;
        end
        if (b_if.o_sck && !b_p_sck) begin
            b_rises++;
            if (b_rises == 1) b_first_rise = b_cyc;
            b_mosi = {b_mosi[6:0], b_if.o_mosi};
        end
        if (!b_if.o_sck && b_p_sck) begin
            b_falls++;
            if (b_falls == 8) b_last_fall = b_cyc;
        end
        b_p_sck = b_if.o_sck;
        b_p_ss  = b_if.o_ss;
    end

    // ---------------- stimulus helpers (call at a negedge) ----------------
    task automatic launch(input bit sel, input logic [7:0] tx);
        if (sel) begin
            b_if.i_tx_data = tx;
            b_if.i_start   = 1'b1;
        end else begin
            m_if.i_tx_data = tx;
            m_if.i_start   = 1'b1;
        end
        @(posedge clk);
        #1;
        b_if.i_start = 1'b0;
        m_if.i_start = 1'b0;
        rise_cnt  = 0;
        mosi_byte = '0;
        hi_q.delete();
        lo_q.delete();
    endtask

    task automatic wait_done(input bit sel, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!(sel ? b_if.o_done : m_if.o_done) && cyc < 500);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (m_if.o_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", m_if.o_sck); end
        checks++; if (m_if.o_ss !== 1'b1) begin errors++; $display("FAIL reset_ss: got %b expected 1", m_if.o_ss); end
        checks++; if (m_if.o_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", m_if.o_mosi); end
        checks++; if (m_if.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", m_if.o_busy); end
        checks++; if (m_if.o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", m_if.o_done); end
        checks++; if (m_if.o_rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h expected 00", m_if.o_rx_data); end
        checks++; if (b_if.o_ss !== 1'b1) begin errors++; $display("FAIL reset_bnd_ss: got %b expected 1", b_if.o_ss); end
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if ({m_if.o_sck, m_if.o_ss, m_if.o_mosi, m_if.o_busy, m_if.o_done, m_if.o_rx_data} !== {5'b01000, 8'h00})
                bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL reset_stable: got %0d bad cycles expected 0", bad); end
        $display("reset: idle outputs checked for 50 cycles");
    endtask

    task automatic test_single();
        int cyc;
        s_arr[0] = 8'h3C;
        m_if.i_hold = 1'b0;
        @(negedge clk);
        launch(0, 8'hA5);
        wait_done(0, cyc);
        checks++; if (cyc !== 69) begin errors++; $display("FAIL single_latency: got %0d expected 69", cyc); end
        checks++; if (m_if.o_rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx: got %h expected 3c", m_if.o_rx_data); end
        checks++; if (mosi_byte !== 8'hA5) begin errors++; $display("FAIL single_mosi: got %h expected a5", mosi_byte); end
        checks++; if (rise_cnt !== 8) begin errors++; $display("FAIL single_pulses: got %0d expected 8", rise_cnt); end
        checks++; if (hi_q.size() !== 8) begin errors++; $display("FAIL single_hi_count: got %0d expected 8", hi_q.size()); end
        foreach (hi_q[i]) begin
            checks++; if (hi_q[i] !== 4) begin errors++; $display("FAIL single_hi_width[%0d]: got %0d expected 4", i, hi_q[i]); end
        end
        checks++; if (lo_q.size() !== 7) begin errors++; $display("FAIL single_lo_count: got %0d expected 7", lo_q.size()); end
        foreach (lo_q[i]) begin
            checks++; if (lo_q[i] !== 4) begin errors++; $display("FAIL single_lo_width[%0d]: got %0d expected 4", i, lo_q[i]); end
        end
        @(negedge clk);
        checks++; if (m_if.o_ss !== 1'b1) begin errors++; $display("FAIL single_ss_after: got %b expected 1", m_if.o_ss); end
        checks++; if (m_if.o_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b expected 0", m_if.o_done); end
        $display("single: tx=a5 rx=%h latency=%0d", m_if.o_rx_data, cyc);
    endtask

    task automatic test_back_to_back();
        logic [7:0] tx_v   [4] = '{8'hAA, 8'hFF, 8'h00, 8'hAA};
        logic [7:0] dout_v [4] = '{8'h00, 8'hAA, 8'hFF, 8'hBE};
        int cyc, rises0;
        foreach (dout_v[i]) s_arr[i] = dout_v[i];
        din_q.delete();
        m_if.i_hold = 1'b1;
        rises0 = ss_rise_cnt;
        @(negedge clk);
        launch(0, tx_v[0]);
        for (int i = 0; i < 4; i++) begin
            wait_done(0, cyc);
            checks++; if (cyc !== 69) begin errors++; $display("FAIL held_latency[%0d]: got %0d expected 69", i, cyc); end
            checks++; if (m_if.o_rx_data !== dout_v[i]) begin errors++; $display("FAIL held_rx[%0d]: got %h expected %h", i, m_if.o_rx_data, dout_v[i]); end
            checks++; if (m_if.o_ss !== 1'b0) begin errors++; $display("FAIL held_ss[%0d]: got %b expected 0", i, m_if.o_ss); end
            $display("held: byte %0d tx=%h rx=%h", i, tx_v[i], m_if.o_rx_data);
            if (i < 3) launch(0, tx_v[i + 1]);
        end
        checks++; if (ss_rise_cnt - rises0 !== 0) begin errors++; $display("FAIL held_ss_rises: got %0d expected 0", ss_rise_cnt - rises0); end
        m_if.i_hold = 1'b0;
        @(negedge clk);
        checks++; if (m_if.o_ss !== 1'b1) begin errors++; $display("FAIL held_release: got %b expected 1", m_if.o_ss); end
        checks++; if (din_q.size() !== 4) begin errors++; $display("FAIL held_din_count: got %0d expected 4", din_q.size()); end
        foreach (din_q[i]) begin
            if (i < 4) begin
                checks++; if (din_q[i] !== tx_v[i]) begin errors++; $display("FAIL held_din[%0d]: got %h expected %h", i, din_q[i], tx_v[i]); end
            end
        end
    endtask

    task automatic test_busy();
        int cyc, d0;
        s_arr[0] = 8'h5E;
        d0 = done_cnt;
        @(negedge clk);
        launch(0, 8'hC3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        m_if.i_tx_data = 8'h11;
        m_if.i_start = 1'b1;
        @(posedge clk);
        #1 m_if.i_start = 1'b0;
        wait_done(0, cyc);
        checks++; if (cyc + 10 !== 69) begin errors++; $display("FAIL busy_latency: got %0d expected 69", cyc + 10); end
        checks++; if (mosi_byte !== 8'hC3) begin errors++; $display("FAIL busy_mosi: got %h expected c3", mosi_byte); end
        checks++; if (m_if.o_rx_data !== 8'h5E) begin errors++; $display("FAIL busy_rx: got %h expected 5e", m_if.o_rx_data); end
        repeat (100) @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt - d0); end
        checks++; if (m_if.o_busy !== 1'b0) begin errors++; $display("FAIL busy_idle: got %b expected 0", m_if.o_busy); end
        $display("busy: tx=c3 with ignored start, rx=%h", m_if.o_rx_data);
    endtask

    task automatic test_reset_mid();
        int cyc, d0, guard;
        s_arr[0] = 8'hFF;
        @(negedge clk);
        launch(0, 8'h96);
        guard = 0;
        while (rise_cnt < 3 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (rise_cnt !== 3) begin errors++; $display("FAIL mid_third_rise: got %0d expected 3", rise_cnt); end
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({m_if.o_sck, m_if.o_ss, m_if.o_busy, m_if.o_mosi} !== 4'b0100) begin
            errors++; $display("FAIL mid_abort: got sck/ss/busy/mosi=%b expected 0100", {m_if.o_sck, m_if.o_ss, m_if.o_busy, m_if.o_mosi});
        end
        repeat (100) @(negedge clk);
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt - d0); end
        s_arr[0] = 8'h69;
        launch(0, 8'h5A);
        wait_done(0, cyc);
        checks++; if (cyc !== 69) begin errors++; $display("FAIL mid_next_latency: got %0d expected 69", cyc); end
        checks++; if (mosi_byte !== 8'h5A) begin errors++; $display("FAIL mid_next_mosi: got %h expected 5a", mosi_byte); end
        checks++; if (m_if.o_rx_data !== 8'h69) begin errors++; $display("FAIL mid_next_rx: got %h expected 69", m_if.o_rx_data); end
        $display("reset_mid: aborted 96, then tx=5a rx=%h latency=%0d", m_if.o_rx_data, cyc);
    endtask

    task automatic test_boundary();
        int cyc;
        b_if.i_hold = 1'b0;
        @(negedge clk);
        launch(1, 8'h80);
        wait_done(1, cyc);
        checks++; if (cyc !== 19) begin errors++; $display("FAIL bnd_latency: got %0d expected 19", cyc); end
        checks++; if (b_if.o_rx_data !== 8'h01) begin errors++; $display("FAIL bnd_rx: got %h expected 01", b_if.o_rx_data); end
        checks++; if (b_mosi !== 8'h80) begin errors++; $display("FAIL bnd_mosi: got %h expected 80", b_mosi); end
        checks++; if (b_rises !== 8) begin errors++; $display("FAIL bnd_pulses: got %0d expected 8", b_rises); end
        checks++; if (b_last_fall - b_first_rise !== 15) begin errors++; $display("FAIL bnd_toggle: got %0d expected 15", b_last_fall - b_first_rise); end
        $display("boundary: tx=80 rx=%h latency=%0d", b_if.o_rx_data, cyc);
    endtask

    initial begin
        m_if.i_start = 1'b0; m_if.i_tx_data = '0; m_if.i_hold = 1'b0;
        b_if.i_start = 1'b0; b_if.i_tx_data = '0; b_if.i_hold = 1'b0;
        foreach (s_arr[i]) s_arr[i] = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        test_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
